// File: rtl/sram_like_mem_responder.sv
// sram_like_mem_responder
// Memory-side responder for an SRAM-like req/addr_ok + data_ok interface.
// Requests are accepted one per cycle, answered in order after a fixed
// LATENCY, and the number of unanswered requests is capped at
// MAX_OUTSTANDING. Backed by a 2**ADDR_WIDTH x 32-bit word array whose
// contents survive reset.
module sram_like_mem_responder #(
  parameter int ADDR_WIDTH      = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Byte-lane enables for a store of the given size at the given byte offset.
  // Halfword stores ignore offset[0]; word stores ignore the offset entirely.
  function automatic logic [3:0] lane_enable(input logic [1:0] sz,
                                             input logic [1:0] offset);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic                  accept;
  logic [3:0]            outstanding;
  logic [LATENCY-1:0]    vld_p;
  logic [31:0]           data_p [LATENCY];
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same words and are deliberately dropped.
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign idx = addr[ADDR_WIDTH+1:2];
  assign be  = lane_enable(size, addr[1:0]);

  // A response retiring this cycle frees a slot in the same cycle, so the
  // cap never costs a bubble when the stream is already at the limit.
  assign addr_ok = req && ((outstanding < 4'(MAX_OUTSTANDING)) || data_ok);

  // Acceptance while reset is held has no effect on array, pipeline or count.
  assign accept = req && addr_ok && !reset;

  assign data_ok = vld_p[LATENCY-1];
  // Payload registers are not reset; gating by valid keeps rdata at 0
  // during reset and between responses.
  assign rdata   = data_ok ? data_p[LATENCY-1] : '0;

  // Array write port: commits enabled byte lanes at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response valid pipeline: a request accepted in cycle n emerges in n+LATENCY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int k = 1; k < LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Response payload pipeline: reads sample the pre-write word, writes carry 0.
  always_ff @(posedge clk) begin
    data_p[0] <= wr ? 32'h0 : mem[idx];
    for (int k = 1; k < LATENCY; k++) begin
      data_p[k] <= data_p[k-1];
    end
  end

  // Outstanding count: +1 on accept, -1 on response, unchanged for both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Directed testbench for sram_like_mem_responder.
// Instance a: LATENCY=2, MAX_OUTSTANDING=4 (functional, burst, reset, alias).
// Instance b: LATENCY=6, MAX_OUTSTANDING=2 (outstanding cap, reset of count).
module tb_sram_like_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, req_a, wr_a, addr_ok_a, data_ok_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, wdata_a, rdata_a;

  logic        reset_b, req_b, wr_b, addr_ok_b, data_ok_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_checks = 0;
  int n_errors = 0;

  sram_like_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2), .MAX_OUTSTANDING(4)) dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .wr(wr_a), .size(size_a),
    .addr(addr_a), .wdata(wdata_a), .addr_ok(addr_ok_a), .data_ok(data_ok_a),
    .rdata(rdata_a)
  );

  sram_like_mem_responder #(.ADDR_WIDTH(12), .LATENCY(6), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .wr(wr_b), .size(size_b),
    .addr(addr_b), .wdata(wdata_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
    .rdata(rdata_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // One cycle: drive request at posedge+1, sample at negedge, step to next posedge+1.
  task automatic cyc(input bit b, input logic r, input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic e_aok, input logic e_dok, input logic [31:0] e_rd,
                     input string tag);
    if (b) begin
      req_b = r; wr_b = w; size_b = s; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; wr_a = w; size_a = s; addr_a = a; wdata_a = d;
    end
    #4;
    if (b) begin
      check({tag, " addr_ok"}, {31'b0, addr_ok_b}, {31'b0, e_aok});
      check({tag, " data_ok"}, {31'b0, data_ok_b}, {31'b0, e_dok});
      if (e_dok) check({tag, " rdata"}, rdata_b, e_rd);
    end else begin
      check({tag, " addr_ok"}, {31'b0, addr_ok_a}, {31'b0, e_aok});
      check({tag, " data_ok"}, {31'b0, data_ok_a}, {31'b0, e_dok});
      if (e_dok) check({tag, " rdata"}, rdata_a, e_rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1; req_a = 1'b0; wr_a = 1'b0; size_a = 2'd2; addr_a = '0; wdata_a = '0;
    reset_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; size_b = 2'd2; addr_b = '0; wdata_b = '0;
    @(posedge clk);
    #1;

    // Reset state, and addr_ok follows req during reset
    cyc(0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, "rst_idle");
    #4;
    check("rst rdata", rdata_a, 32'h0);
    @(posedge clk);
    #1;
    cyc(0, 1, 0, 2'd2, 32'h0, 32'h0, 1, 0, 32'h0, "rst_req");
    cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, 1, 0, 32'h0, "rst_req_b");
    req_b = 1'b0;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Word write then read
    cyc(0, 1, 1, 2'd2, 32'h40, 32'hDEADBEEF, 1, 0, 32'h0, "wr40");
    cyc(0, 1, 0, 2'd2, 32'h40, 32'h0,        1, 0, 32'h0, "rd40");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 1, 32'h0, "rsp_wr40");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF, "rsp_rd40");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 0, 32'h0, "idle1");

    // Byte / halfword merge
    cyc(0, 1, 1, 2'd2, 32'h80, 32'h11223344, 1, 0, 32'h0, "wr80w");
    cyc(0, 1, 1, 2'd0, 32'h81, 32'h0000AA00, 1, 0, 32'h0, "wr81b");
    cyc(0, 1, 1, 2'd1, 32'h82, 32'hBBCC0000, 1, 1, 32'h0, "wr82h");
    cyc(0, 1, 0, 2'd2, 32'h80, 32'h0,        1, 1, 32'h0, "rd80");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 1, 32'h0, "rsp_wr82");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 1, 32'hBBCCAA44, "rsp_rd80");
    cyc(0, 0, 0, 2'd2, 32'h0,  32'h0,        0, 0, 32'h0, "idle2");

    // Line fill then 8-read burst with req held
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 1, 2'd2, 32'h100 + 32'(4*i), val(i), 1, (i >= 2), 32'h0,
          $sformatf("fill%0d", i));
    for (int j = 0; j < 10; j++)
      cyc(0, (j < 8), 0, 2'd2, 32'h100 + 32'(4*(j % 8)), 32'h0, (j < 8), 1,
          (j < 2) ? 32'h0 : val(j - 2), $sformatf("burst%0d", j));
    cyc(0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, "idle3");

    // Outstanding cap on instance b
    for (int i = 0; i < 21; i++)
      cyc(1, (i < 14), 1, 2'd2, 32'h0, 32'(i),
          (i < 2) || (i == 6) || (i == 7) || (i == 12) || (i == 13),
          (i == 6) || (i == 7) || (i == 12) || (i == 13) || (i == 18) || (i == 19),
          32'h0, $sformatf("cap%0d", i));

    // Reset at the cap on instance b: pending responses dropped, count cleared
    cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, 1, 0, 32'h0, "brst0");
    cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, 1, 0, 32'h0, "brst1");
    cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, "brst2");
    reset_b = 1'b1;
    cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, 1, 0, 32'h0, "brst3");
    reset_b = 1'b0;
    for (int i = 4; i < 12; i++)
      cyc(1, 1, 1, 2'd2, 32'h0, 32'h0, (i < 6) || (i >= 10), (i >= 10), 32'h0,
          $sformatf("brst%0d", i));
    req_b = 1'b0;

    // Reset mid-burst on instance a
    cyc(0, 1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 32'h0, "arst0");
    cyc(0, 1, 0, 2'd2, 32'h104, 32'h0, 1, 0, 32'h0, "arst1");
    cyc(0, 1, 0, 2'd2, 32'h108, 32'h0, 1, 1, val(0), "arst2");
    reset_a = 1'b1;
    cyc(0, 1, 0, 2'd2, 32'h10C, 32'h0,        1, 0, 32'h0, "arst3");
    cyc(0, 1, 1, 2'd2, 32'h100, 32'hFFFFFFFF, 1, 0, 32'h0, "arst4");
    reset_a = 1'b0;
    cyc(0, 0, 0, 2'd2, 32'h0,   32'h0, 0, 0, 32'h0, "arst5");
    cyc(0, 0, 0, 2'd2, 32'h0,   32'h0, 0, 0, 32'h0, "arst6");
    cyc(0, 1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 32'h0, "arst7");
    cyc(0, 0, 0, 2'd2, 32'h0,   32'h0, 0, 0, 32'h0, "arst8");
    cyc(0, 0, 0, 2'd2, 32'h0,   32'h0, 0, 1, val(0), "arst9");

    // Address aliasing modulo 2**14 bytes
    cyc(0, 1, 1, 2'd2, 32'h0000_4000, 32'h5A5A5A5A, 1, 0, 32'h0, "alias_wr");
    cyc(0, 1, 0, 2'd2, 32'h0000_0000, 32'h0,        1, 0, 32'h0, "alias_rd");
    cyc(0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 1, 32'h0, "alias_rsp_wr");
    cyc(0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 1, 32'h5A5A5A5A, "alias_rsp_rd");
    cyc(0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0, "idle4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_like_mem_responder.md
Name: sram_like_mem_responder

Overview:
- Memory-side responder for the SRAM-like request/response interface driven by the cache controllers.
- Accepts one request per cycle on req/addr_ok and returns a one-cycle data_ok pulse with rdata after a fixed latency.
- Keeps responses strictly in order and caps the number of outstanding requests.
- Backed by an internal word array; used as the memory stand-in behind iCache/dCache in integration benches and FPGA bring-up.

Parameters:
- ADDR_WIDTH, 12, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from acceptance to data_ok; legal range 1..8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request valid; held by the initiator until addr_ok
- wr  input  1  1 = write, 0 = read
- size  input  2  0 = byte, 1 = halfword, 2 or 3 = word
- addr  input  32  byte address
- wdata  input  32  write data, lane-aligned to addr[1:0]
- addr_ok  output  1  request accepted this cycle (combinational)
- data_ok  output  1  one-cycle response pulse
- rdata  output  32  read word, valid while data_ok=1; 0 for write responses

Behaviour:
- Acceptance:
  - addr_ok = req && (outstanding < MAX_OUTSTANDING || data_ok).
  - A request is accepted in a cycle where req && addr_ok. addr_ok never depends on wr, size or addr.
- Indexing: word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 2**(ADDR_WIDTH+2).
- Write, committed at the accepting edge:
  - Byte lane enables: size 0 -> lane addr[1:0]; size 1 -> lanes {addr[1],0} and {addr[1],1}, with addr[0] ignored; size 2/3 -> all four lanes, with addr[1:0] ignored.
  - Unselected lanes are unchanged.
- Read:
  - The word is sampled from the array at the accepting edge, after any write committed at that same edge is excluded. Each request sees memory as of before its own acceptance.
  - Reads always return the full 32-bit word. Sub-word extraction is the initiator's job.
- Response timing:
  - A request accepted in cycle n produces data_ok=1 in cycle n+LATENCY for exactly one cycle.
  - rdata = sampled word for a read, 0 for a write. Writes also get a data_ok.
  - Responses are in acceptance order. At most one data_ok per cycle; fixed latency guarantees no collision.
- Implementation: a LATENCY-deep delay pipeline of {valid, rdata}, plus an outstanding counter 0..MAX_OUTSTANDING.
- Outstanding counter update per cycle: +1 on accept, -1 on data_ok, unchanged when both happen.
  - When LATENCY > MAX_OUTSTANDING, addr_ok drops once the cap is reached and reopens in the cycle of the next data_ok.
- Back-to-back traffic: with MAX_OUTSTANDING >= LATENCY, a continuous req stream is accepted every cycle and data_ok is continuous after the initial LATENCY cycles. This matches the iCache line-refill pattern.
- Idle: with no req, addr_ok=0. The pipeline drains normally.
- Reset (asynchronous, any time, including mid-burst):
  - data_ok=0, rdata=0, pipeline valid bits cleared, outstanding=0.
  - Pending responses are discarded and never emitted.
  - Array contents are not reset. Writes committed before reset are retained.
  - addr_ok follows its equation: it is 1 during reset if req=1. The initiator is held in reset alongside, so acceptance during reset has no effect; writes are blocked while reset=1.
- Array contents at power-up are undefined. Benches must write before reading.

Test Plan:
- Word write/read: write 0xDEADBEEF to 0x40 at cycle 0, read 0x40 at cycle 1, LATENCY=2 -> data_ok in cycles 2 (rdata=0) and 3 (rdata=0xDEADBEEF).
- Byte/half merge: word write 0x11223344 to 0x80, byte write 0xAA at 0x81, half write 0xBBCC at 0x82, then read 0x80 -> rdata=0xBBCCAA44.
- Line burst: 8 consecutive read requests to 0x100..0x11C, req held high, MAX_OUTSTANDING=4, LATENCY=2 -> addr_ok high all 8 cycles; data_ok high cycles 2..9 with words in address order.
- Outstanding cap: LATENCY=6, MAX_OUTSTANDING=2, req held high -> addr_ok high cycles 0,1, low cycles 2..5, high again cycle 6 (coincident with the first data_ok); never more than 2 unanswered.
- Reset mid-burst: assert reset after 3 of 8 burst reads accepted -> no data_ok during or after reset for those requests; outstanding=0; a fresh read of a previously written word returns the pre-reset value.
- Aliasing: ADDR_WIDTH=12, write 0x5A5A5A5A to 0x00004000, read 0x00000000 -> rdata=0x5A5A5A5A.
